slide_board_engine: RTL

Parametrised N×N sliding-puzzle board engine and successor to the fixed 4×4 RAM-based game datapath/control pair. Holds the board in internal registers and owns these functions: shuffle from an external random source, legal-move checking and tile swaps, a saturating move counter, and registered solved detection. Sits between keyboard_decoder (direction/move/start) and basicDisplay, which reads cells through a combinational read port and redraws only the cells announced on the update strobe.

---
 rtl/slide_pkg.sv | 25 ++
 rtl/slide_solved_check.sv | 35 +++
 rtl/slide_board_engine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/slide_pkg.sv
// Shared encodings for the sliding-puzzle engine: move directions, FSM states, solved-board layout.
package slide_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int ID_BLANK = 0;

    typedef enum logic [2:0] {
        IDLE,
        SHUFFLE,
        PLAY,
        UPD0,
        UPD1,
        WON
    } state_t;

    // Tile ID held by cell idx on a solved board of `cells` cells.
    function automatic int home_id(input int idx, input int cells);
        return (idx == cells - 1) ? ID_BLANK : idx + 1;
    endfunction

endpackage

// File: rtl/slide_solved_check.sv
// Registered solved flag: compares every cell against its home tile, one cycle behind the board.
module slide_solved_check
    import slide_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic [N*N*$clog2(N*N)-1:0]     board,
    output logic                           solved
);

    localparam int NC     = N * N;
    localparam int CELL_W = $clog2(NC);

    logic match;

    always_comb begin
        match = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (board[i*CELL_W +: CELL_W] != CELL_W'(home_id(i, NC))) begin
                match = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            solved <= 1'b1;
        end else begin
            solved <= match;
        end
    end

endmodule

// File: rtl/slide_board_engine.sv
// N x N sliding-puzzle engine: shuffle, legal-move swap, saturating move count, update strobes.
// One swap per cycle; player moves only accepted in PLAY, anything else is dropped (no queueing).
module slide_board_engine
    import slide_pkg::*;
#(
    parameter int N             = 4,
    parameter int CELL_W        = $clog2(N*N),
    parameter int CNT_W         = 8,
    parameter int SHUFFLE_MOVES = 64
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic              move_valid,
    input  logic [1:0]        move_dir,
    input  logic [1:0]        rand_in,
    input  logic [CELL_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_id,
    output logic              upd_valid,
    output logic [CELL_W-1:0] upd_addr,
    output logic [CELL_W-1:0] blank_pos,
    output logic [CNT_W-1:0]  move_count,
    output logic              busy,
    output logic              ready,
    output logic              solved
);

    localparam int NC     = N * N;
    localparam int RC_W   = $clog2(N);
    localparam int STEP_W = $clog2(SHUFFLE_MOVES + 1);

    state_t state, state_nxt;

    logic [NC-1:0][CELL_W-1:0] board;
    logic [RC_W-1:0]           blank_row, blank_col, tgt_row, tgt_col;
    logic [CELL_W-1:0]         tgt_pos, prev_blank;
    logic [STEP_W-1:0]         step_cnt;
    logic [1:0]                dir;
    logic                      legal, board_home, solved_q;
    logic                      do_move, new_game, cnt_inc, step_inc;

    assign rd_id = board[rd_addr];

    // Blank's destination for the active direction; legal only if it stays on the board.
    always_comb begin
        dir     = (state == SHUFFLE) ? rand_in : move_dir;
        tgt_row = blank_row;
        tgt_col = blank_col;
        tgt_pos = blank_pos;
        legal   = 1'b0;
        case (dir)
            DIR_UP: begin
                legal   = (blank_row != RC_W'(N - 1));
                tgt_row = blank_row + RC_W'(1);
                tgt_pos = blank_pos + CELL_W'(N);
            end
            DIR_DOWN: begin
                legal   = (blank_row != '0);
                tgt_row = blank_row - RC_W'(1);
                tgt_pos = blank_pos - CELL_W'(N);
            end
            DIR_LEFT: begin
                legal   = (blank_col != RC_W'(N - 1));
                tgt_col = blank_col + RC_W'(1);
                tgt_pos = blank_pos + CELL_W'(1);
            end
            default: begin
                legal   = (blank_col != '0);
                tgt_col = blank_col - RC_W'(1);
                tgt_pos = blank_pos - CELL_W'(1);
            end
        endcase
    end

    // Shuffle exit must see the board as it is now, not the one-cycle-late registered flag.
    always_comb begin
        board_home = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (board[i] != CELL_W'(home_id(i, NC))) begin
                board_home = 1'b0;
            end
        end
    end

    slide_solved_check #(.N(N)) u_solved (
        .clock  (clock),
        .resetN (resetN),
        .board  (board),
        .solved (solved_q)
    );

    always_comb begin
        state_nxt = state;
        do_move   = 1'b0;
        new_game  = 1'b0;
        cnt_inc   = 1'b0;
        step_inc  = 1'b0;
        busy      = 1'b0;
        ready     = 1'b0;
        solved    = 1'b0;
        upd_valid = 1'b0;
        upd_addr  = '0;
        case (state)
            IDLE: begin
                solved = 1'b1;
                if (start) begin
                    new_game  = 1'b1;
                    state_nxt = SHUFFLE;
                end
            end
            SHUFFLE: begin
                busy = 1'b1;
                if (step_cnt == STEP_W'(SHUFFLE_MOVES) && !board_home) begin
                    state_nxt = PLAY;
                end else begin
                    do_move  = legal;
                    step_inc = 1'b1;
                end
            end
            PLAY: begin
                ready = 1'b1;
                if (start) begin
                    new_game  = 1'b1;
                    state_nxt = SHUFFLE;
                end else if (move_valid && legal) begin
                    do_move   = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = UPD0;
                end
            end
            UPD0: begin
                busy      = 1'b1;
                upd_valid = 1'b1;
                upd_addr  = prev_blank;
                state_nxt = UPD1;
            end
            UPD1: begin
                busy      = 1'b1;
                upd_valid = 1'b1;
                upd_addr  = blank_pos;
                state_nxt = solved_q ? WON : PLAY;
            end
            WON: begin
                solved = 1'b1;
                if (start) begin
                    new_game  = 1'b1;
                    state_nxt = SHUFFLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= IDLE;
            for (int i = 0; i < NC; i++) begin
                board[i] <= CELL_W'(home_id(i, NC));
            end
            blank_pos  <= CELL_W'(NC - 1);
            blank_row  <= RC_W'(N - 1);
            blank_col  <= RC_W'(N - 1);
            prev_blank <= '0;
            step_cnt   <= '0;
            move_count <= '0;
        end else begin
            state <= state_nxt;
            if (do_move) begin
                board[blank_pos] <= board[tgt_pos];
                board[tgt_pos]   <= CELL_W'(ID_BLANK);
                prev_blank       <= blank_pos;
                blank_pos        <= tgt_pos;
                blank_row        <= tgt_row;
                blank_col        <= tgt_col;
            end
            if (new_game) begin
                step_cnt   <= '0;
                move_count <= '0;
            end else begin
                if (step_inc && step_cnt != STEP_W'(SHUFFLE_MOVES)) begin
                    step_cnt <= step_cnt + STEP_W'(1);
                end
                if (cnt_inc && move_count != '1) begin
                    move_count <= move_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
